// File: rtl/shared_pkg.sv
// Shared definitions for the shared-unit result accumulator: FSM encoding,
// mode constants and default sizing.
package shared_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int unsigned ACC_W_DEF     = 8;
  localparam int unsigned N_SAMPLES_DEF = 8;

endpackage

// File: rtl/shared_acc_alu.sv
// Combinational add/subtract of a zero-extended 2-bit sample into the running total.
// SHARED_ACC_SATURATE_EN clamps the result on signed overflow instead of wrapping.
module shared_acc_alu
  import shared_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [1:0]       i_s,
  input  logic             i_m,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_opnd;
  logic [ACC_W-1:0] w_sum;

  assign w_ext  = {{(ACC_W-2){1'b0}}, i_s};
  // Subtraction is an add of the negated operand so one overflow rule covers both.
  assign w_opnd = (i_m == MODE_SUB) ? (~w_ext + 1'b1) : w_ext;
  assign w_sum  = i_acc + w_opnd;
  assign o_ovf  = (i_acc[ACC_W-1] == w_opnd[ACC_W-1]) && (w_sum[ACC_W-1] != i_acc[ACC_W-1]);

`ifdef SHARED_ACC_SATURATE_EN
  always_comb begin
    o_acc = w_sum;
    if (o_ovf) begin
      // Both operands share the sign of i_acc, which gives the overflow direction.
      o_acc = i_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign o_acc = w_sum;
`endif

endmodule

// File: rtl/shared_result_acc.sv
// Burst accumulator for shared-unit results with done pulse and sticky overflow.
// Optional SHARED_ACC_SATURATE_EN selects saturating instead of wrapping arithmetic.
module shared_result_acc
  import shared_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [1:0]       in_s,
  input  logic             in_m,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic [ACC_W-1:0] w_acc_next;
  logic             w_ovf;

  shared_acc_alu #(
    .ACC_W(ACC_W)
  ) u_alu (
    .i_acc(r_acc),
    .i_s  (in_s),
    .i_m  (in_m),
    .o_acc(w_acc_next),
    .o_ovf(w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            r_ovf <= r_ovf | w_ovf;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign acc        = r_acc;
  assign sample_cnt = r_cnt;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_ovf;

endmodule

// File: doc/shared_result_acc.md
Name: shared_result_acc

Overview:
- Downstream consumer of the 2-bit shared arithmetic unit: takes its {s1,s0} result and the mode bit m that produced it.
- Accumulates a fixed-length burst of results into a signed running total.
- Reports completion and overflow to the controller or display stage that follows.

Parameters:
- ACC_W, 8, accumulator width in bits; minimum 4.
- N_SAMPLES, 8, accepted samples per burst; minimum 1.
- CNT_W, 4, sample counter width; must satisfy 2^CNT_W > N_SAMPLES.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a burst.
- in_valid  input  1  in_s/in_m hold a valid shared-unit result this cycle.
- in_s  input  2  shared-unit result {s1,s0}, unsigned 0..3.
- in_m  input  1  shared-unit mode bit: 0 = add, 1 = subtract.
- acc  output  ACC_W  two's-complement running total.
- sample_cnt  output  CNT_W  samples accepted in the current burst.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse marking burst completion.
- overflow  output  1  sticky signed-overflow flag for the current burst.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is asynchronous, active-low, on rst_n. Assertion forces all state immediately, independent of clk.
- Reset values:
  - FSM = IDLE, acc = 0, sample_cnt = 0, busy = 0, done = 0, overflow = 0.
  - Reset mid-burst discards the partial burst; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_valid is ignored.
  - start=1 → next cycle RUN; acc, sample_cnt and overflow clear to 0 on that edge.
- RUN:
  - busy=1.
  - On each edge with in_valid=1: acc ← acc + zero-extend(in_s) if in_m=0, else acc − zero-extend(in_s). Arithmetic wraps modulo 2^ACC_W. sample_cnt increments.
  - Overflow: overflow ← 1 when signed overflow occurs, i.e. operands have the same sign and the result sign differs (subtraction treated as add of negation). The flag is sticky until the next start.
  - Sample completion: the edge that accepts sample N_SAMPLES moves to DONE.
  - start during RUN is ignored; there is no restart.
  - in_valid=0 holds all state.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0. acc and sample_cnt hold their final values.
  - in_valid is ignored.
  - Next state is RUN (with clear) if start=1 in this cycle, else IDLE.
- After DONE→IDLE, acc, sample_cnt and overflow keep their final values until the next start.
- Latency: acc reflects a sample on the edge that accepts it (1 cycle). done asserts the cycle after the final sample.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SHARED_ACC_SATURATE_EN.
- Defined: on signed overflow, acc clamps to +2^(ACC_W−1)−1 (positive overflow) or −2^(ACC_W−1) (negative overflow) instead of wrapping. overflow is still set.
- Undefined: wrap-around arithmetic as described in Behaviour.

Decomposition:
- Shared package shared_pkg:
  - FSM state encoding (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2).
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
  - Default ACC_W / N_SAMPLES.
- One natural sub-module: shared_acc_alu.
  - Combinational add/sub of the extended operand.
  - Produces the next acc and the overflow bit.
  - Contains the saturation logic under the macro.
- FSM, counter and registers stay in the top level.

Test Plan:
- Reset then start, 8 samples in_s=2'b11, in_m=0, in_valid every cycle → acc=24, sample_cnt=8, done pulses one cycle after the 8th sample, busy falls with it, overflow=0.
- Alternating in_m=0/1 with in_s=2 over 8 samples, in_valid gapped every other cycle → acc=0. Counter advances only on valid cycles. done timing is measured from the last valid sample.
- ACC_W=4, 8 samples in_s=3, in_m=0 → overflow=1 after the 3rd sample (9 > 7).
  - Without macro: final acc = 24 mod 16 = 8 (reads −8).
  - With SHARED_ACC_SATURATE_EN: final acc = 7.
- start pulsed during RUN (after sample 3) → ignored: burst completes at 8 samples. start asserted in the DONE cycle → immediate RUN, acc=0, overflow=0.
- rst_n driven low asynchronously mid-cycle during RUN at sample 5 → all outputs 0 immediately. No done pulse. in_valid while IDLE leaves acc unchanged.
